// File: rtl/param_reg_file.sv
// -----------------------------------------------------------------------------
// param_reg_file
//
// Purpose:
//   Parametrised register file with DEPTH entries of WIDTH bits, two
//   combinational read ports, one clocked write port, an optional hardwired
//   zero register at index DEPTH-1, and a per-register busy scoreboard used by
//   the pipeline to track in-flight producers.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a write is forwarded to a read port that
//   addresses the same (writable) index in the same cycle, and that port's
//   busy flag shows the post-write state. When undefined, reads and busy flags
//   come from registered state only.
//
// Ports:
//   clk        in   1      clock, all state changes on the rising edge
//   reset      in   1      synchronous active-high reset (clears data and busy)
//   regWrite   in   1      write enable
//   writeReg   in   AW     write index
//   writeData  in   WIDTH  write data
//   readReg1   in   AW     read port 1 index
//   readReg2   in   AW     read port 2 index
//   readData1  out  WIDTH  read port 1 data
//   readData2  out  WIDTH  read port 2 data
//   markBusy   in   1      set busy bit of markReg (producer issued)
//   markReg    in   AW     index to mark busy
//   busy1      out  1      busy state of readReg1
//   busy2      out  1      busy state of readReg2
// -----------------------------------------------------------------------------
module param_reg_file #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 32,
    parameter int AW           = $clog2(DEPTH),
    parameter bit HAS_ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regWrite,
    input  logic [AW-1:0]    writeReg,
    input  logic [WIDTH-1:0] writeData,
    input  logic [AW-1:0]    readReg1,
    input  logic [AW-1:0]    readReg2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    input  logic             markBusy,
    input  logic [AW-1:0]    markReg,
    output logic             busy1,
    output logic             busy2
);

    // Every encodable index gets a flag saying whether it names a real,
    // writable register. Out-of-range indices and the zero register are
    // excluded, so one lookup handles both cases on every port.
    localparam int SLOTS = 1 << AW;

    logic [SLOTS-1:0] valid_mask;

    for (genvar i = 0; i < SLOTS; i++) begin : g_mask
        assign valid_mask[i] = (i < DEPTH) && !(HAS_ZERO_REG && (i == DEPTH - 1));
    end

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_next;

    logic wr_en;
    logic mark_en;

    assign wr_en   = regWrite && valid_mask[writeReg];
    assign mark_en = markBusy && valid_mask[markReg];

    // Scoreboard update: a write retires the producer, a mark issues a new
    // one. The mark is applied last so it wins when both hit the same index.
    // NOTE: every variable driven in always_comb is given a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        busy_next = busy_q;
        if (wr_en) begin
            busy_next[writeReg] = 1'b0;
        end
        if (mark_en) begin
            busy_next[markReg] = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage array is cleared on reset deliberately, since
            // the architecture requires every register to read 0 afterwards;
            // most memories are left unreset to allow RAM mapping.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_en) begin
                regs[writeReg] <= writeData;
            end
            busy_q <= busy_next;
        end
    end

    // Read ports. Both ports share the same logic, indexed by port number.
    logic [AW-1:0]    rd_idx  [2];
    logic [WIDTH-1:0] rd_data [2];
    logic             rd_busy [2];

    always_comb begin
        rd_idx[0] = readReg1;
        rd_idx[1] = readReg2;
        for (int p = 0; p < 2; p++) begin
            // Invalid indices (zero register, out of range) read 0, not busy.
            rd_data[p] = valid_mask[rd_idx[p]] ? regs[rd_idx[p]] : '0;
            rd_busy[p] = valid_mask[rd_idx[p]] && busy_q[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; the port then sees the busy state
            // that will exist after the edge (cleared unless re-marked).
            if (wr_en && (writeReg == rd_idx[p])) begin
                rd_data[p] = writeData;
                rd_busy[p] = markBusy && (markReg == rd_idx[p]);
            end
`endif
        end
    end

    assign readData1 = rd_data[0];
    assign readData2 = rd_data[1];
    assign busy1     = rd_busy[0];
    assign busy2     = rd_busy[1];

endmodule

// File: tb/tb_param_reg_file.sv
// -----------------------------------------------------------------------------
// tb_param_reg_file
//
// Purpose:
//   Self-checking bench for param_reg_file at default parameters
//   (64-bit x 32 entries, zero register at index 31). Directed vectors from a
//   table, hand-written multi-cycle sequences, then randomized traffic checked
//   against an array-based reference model. Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_param_reg_file;

    localparam int WIDTH = 64;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int ZR    = DEPTH - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             reg_write;
    logic [AW-1:0]    write_reg;
    logic [WIDTH-1:0] write_data;
    logic [AW-1:0]    read_reg1;
    logic [AW-1:0]    read_reg2;
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;
    logic             mark_busy;
    logic [AW-1:0]    mark_reg;
    logic             busy1;
    logic             busy2;

    param_reg_file #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .HAS_ZERO_REG(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .regWrite (reg_write),
        .writeReg (write_reg),
        .writeData(write_data),
        .readReg1 (read_reg1),
        .readReg2 (read_reg2),
        .readData1(read_data1),
        .readData2(read_data2),
        .markBusy (mark_busy),
        .markReg  (mark_reg),
        .busy1    (busy1),
        .busy2    (busy2)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs held across one rising edge, then the
    // write/mark/reset controls are dropped and outputs are compared.
    // ------------------------------------------------------------------
    typedef struct {
        logic             rst;
        logic             we;
        logic [AW-1:0]    wr;
        logic [WIDTH-1:0] wd;
        logic             mb;
        logic [AW-1:0]    mr;
        logic [AW-1:0]    r1;
        logic [AW-1:0]    r2;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        logic             eb1;
        logic             eb2;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic we, input int wr,
                                input logic [WIDTH-1:0] wd, input logic mb, input int mr,
                                input int r1, input int r2,
                                input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                                input logic eb1, input logic eb2);
        vec_t v;
        v.rst = rst; v.we = we; v.wr = AW'(wr); v.wd = wd;
        v.mb = mb; v.mr = AW'(mr); v.r1 = AW'(r1); v.r2 = AW'(r2);
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    task automatic idle_inputs();
        reset      = 1'b0;
        reg_write  = 1'b0;
        mark_busy  = 1'b0;
    endtask

    task automatic apply_vec(input int n, input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        reg_write  = v.we;
        write_reg  = v.wr;
        write_data = v.wd;
        mark_busy  = v.mb;
        mark_reg   = v.mr;
        read_reg1  = v.r1;
        read_reg2  = v.r2;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check($sformatf("vec%0d_data1", n), read_data1, v.e1);
        check($sformatf("vec%0d_data2", n), read_data2, v.e2);
        check($sformatf("vec%0d_busy1", n), {63'b0, busy1}, {63'b0, v.eb1});
        check($sformatf("vec%0d_busy2", n), {63'b0, busy2}, {63'b0, v.eb2});
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain arrays updated by the architectural rules.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] model_mem  [DEPTH];
    logic             model_busy [DEPTH];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_busy[i] = 1'b0;
        end
    endtask

    // Value a read port should show this cycle, before the edge.
    function automatic logic [WIDTH-1:0] model_read(input int idx, input logic we,
                                                   input int wr, input logic [WIDTH-1:0] wd);
        logic [WIDTH-1:0] val;
        val = (idx == ZR) ? '0 : model_mem[idx];
`ifdef REGFILE_BYPASS_EN
        if (we && wr == idx && idx != ZR) val = wd;
`else
        if (we && wr == idx) val = val;
`endif
        return val;
    endfunction

    function automatic logic model_busy_rd(input int idx, input logic we, input int wr,
                                           input logic mb, input int mr);
        logic b;
        b = (idx == ZR) ? 1'b0 : model_busy[idx];
`ifdef REGFILE_BYPASS_EN
        if (we && wr == idx && idx != ZR) b = mb && (mr == idx);
`else
        if (mb && mr == idx) b = b;
`endif
        return b;
    endfunction

    vec_t vecs [13];

    initial begin
        logic [WIDTH-1:0] old_val;
        idle_inputs();
        write_reg  = '0;
        write_data = '0;
        mark_reg   = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // ---------------- reset flush ----------------
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5; write_data = 64'hDEADBEEF_CAFEF00D;
        read_reg1 = 5; read_reg2 = 5;
        @(posedge clk); #1; idle_inputs(); #1;
        check("flush_pre_write", read_data1, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1; idle_inputs(); #1;
        check("flush_reg5_data", read_data1, '0);
        check("flush_reg5_busy", {63'b0, busy1}, '0);
        for (int i = 0; i < DEPTH; i++) begin
            read_reg1 = AW'(i);
            read_reg2 = AW'(DEPTH - 1 - i);
            #1;
            check($sformatf("flush_all_rd1_%0d", i), read_data1, '0);
            check($sformatf("flush_all_rd2_%0d", i), read_data2, '0);
        end

        // ---------------- directed table ----------------
        vecs[0]  = mk(1, 0, 0,  64'h0,                  0, 0,  0,  31, 64'h0, 64'h0, 0, 0);
        vecs[1]  = mk(0, 1, 3,  64'h0123456789ABCDEF,   0, 0,  3,  3,
                      64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0, 0);
        vecs[2]  = mk(0, 1, 30, 64'hFFFF0000FFFF0000,   0, 0,  30, 3,
                      64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF, 0, 0);
        vecs[3]  = mk(0, 0, 3,  64'h1, 0, 0, 3,  30, 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 0, 0);
        vecs[4]  = mk(0, 0, 30, 64'h1, 0, 0, 30, 3,  64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF, 0, 0);
        vecs[5]  = mk(0, 0, 3,  64'h1, 0, 0, 3,  30, 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 0, 0);
        vecs[6]  = mk(0, 0, 30, 64'h1, 0, 0, 30, 3,  64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF, 0, 0);
        vecs[7]  = mk(0, 1, 31, 64'hFFFFFFFFFFFFFFFF,   1, 31, 31, 31, 64'h0, 64'h0, 0, 0);
        vecs[8]  = mk(0, 0, 0,  64'h0,                  1, 7,  7,  3,  64'h0, 64'h0123456789ABCDEF, 1, 0);
        vecs[9]  = mk(0, 1, 7,  64'h42,                 0, 0,  7,  7,  64'h42, 64'h42, 0, 0);
        vecs[10] = mk(0, 1, 9,  64'h5A5A,               1, 9,  9,  7,  64'h5A5A, 64'h42, 1, 0);
        vecs[11] = mk(0, 1, 4,  64'h1234,               1, 4,  4,  9,  64'h1234, 64'h5A5A, 1, 1);
        vecs[12] = mk(1, 1, 4,  64'h99,                 1, 4,  4,  9,  64'h0, 64'h0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            apply_vec(i, vecs[i]);
        end

        // ---------------- same-cycle write/read of reg 12 ----------------
        @(negedge clk);
        reg_write = 1'b1; write_reg = 12; write_data = 64'h11;
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        reg_write = 1'b1; write_reg = 12; write_data = 64'h22;
        read_reg1 = 12; read_reg2 = 12;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_rd1", read_data1, 64'h22);
        check("same_cycle_rd2", read_data2, 64'h22);
`else
        check("same_cycle_rd1", read_data1, 64'h11);
        check("same_cycle_rd2", read_data2, 64'h11);
`endif
        @(posedge clk); #1; idle_inputs(); #1;
        check("after_edge_rd1", read_data1, 64'h22);

        // ---------------- randomized traffic vs. model ----------------
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1; idle_inputs();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 99) == 0);
            reg_write  = $urandom_range(0, 1) == 1;
            write_reg  = AW'($urandom_range(0, DEPTH - 1));
            write_data = {$urandom, $urandom};
            mark_busy  = $urandom_range(0, 2) == 0;
            mark_reg   = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, DEPTH - 1));
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, DEPTH - 1));
            read_reg2  = ($urandom_range(0, 3) == 0) ? mark_reg  : AW'($urandom_range(0, DEPTH - 1));
            #1;
            old_val = model_read(int'(read_reg1), reg_write, int'(write_reg), write_data);
            check($sformatf("rand%0d_rd1", cyc), read_data1, old_val);
            check($sformatf("rand%0d_rd2", cyc), read_data2,
                  model_read(int'(read_reg2), reg_write, int'(write_reg), write_data));
            check($sformatf("rand%0d_busy1", cyc), {63'b0, busy1},
                  {63'b0, model_busy_rd(int'(read_reg1), reg_write, int'(write_reg),
                                        mark_busy, int'(mark_reg))});
            check($sformatf("rand%0d_busy2", cyc), {63'b0, busy2},
                  {63'b0, model_busy_rd(int'(read_reg2), reg_write, int'(write_reg),
                                        mark_busy, int'(mark_reg))});
            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                if (reg_write && write_reg != ZR) begin
                    model_mem[write_reg]  = write_data;
                    model_busy[write_reg] = 1'b0;
                end
                if (mark_busy && mark_reg != ZR) begin
                    model_busy[mark_reg] = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
